// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART: parity modes, FSM state
// encodings and the oversampling divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Rounded clock-cycles-per-tick for the 16x oversampling enable.
  function automatic int uart_div(input int freq_hz, input int baud);
    return (freq_hz + 8 * baud) / (16 * baud);
  endfunction

  // Odd parity makes the total count of ones (data + parity) odd.
  function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head word and registered
// full/empty flags; the head only changes on push-to-empty or pop.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int aw = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [aw-1:0]    rd_ptr_q, wr_ptr_q, rd_next;
  logic [aw:0]      count_q, count_d;
  logic [width-1:0] dout_q, dout_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);
  assign rd_next = rd_ptr_q + 1'b1;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
    if (do_pop) begin
      if (count_q != {{aw{1'b0}}, 1'b1}) dout_d = mem_q[rd_next];
      else if (do_push)                  dout_d = din;
    end else if (do_push && empty_q) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_next;
      count_q <= count_d;
      dout_q  <= dout_d;
      full_q  <= count_d[aw];
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: storage array is deliberately not reset; only pointers/flags are, and the head register hides stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_buffered.sv
// Buffered UART: configurable frame format, 16x oversampled receiver,
// TX/RX FIFOs, per-byte error flag and dropped-byte overrun pulse.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int freq_hz    = 50000000,
  parameter int baud       = 115200,
  parameter int data_bits  = 8,
  parameter int parity     = 0,
  parameter int stop_bits  = 1,
  parameter int fifo_depth = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy,
  output logic       tx_idle,
  output logic [7:0] rx_data,
  output logic       rx_error,
  output logic       rx_avail,
  input  logic       rx_ack,
  output logic       rx_overrun
);

  localparam int      div_c      = uart_div(freq_hz, baud);
  localparam int      dw_c       = (div_c > 1) ? $clog2(div_c) : 1;
  localparam logic [7:0] mask_c  = 8'((1 << data_bits) - 1);
  localparam logic [2:0] last_c  = 3'(data_bits - 1);
  localparam logic    stop2_c    = (stop_bits == 2);
  localparam bit      has_par_c  = (parity != 0);
  localparam parity_e par_mode_c = parity_e'(2'(parity));

  logic [dw_c-1:0] div_cnt_q;
  logic            tick16;

  assign tick16 = (div_cnt_q == dw_c'(div_c - 1));

  // NOTE: clocked state is always written with non-blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    div_cnt_q <= '0;
    else if (tick16) div_cnt_q <= '0;
    else             div_cnt_q <= div_cnt_q + 1'b1;
  end

  // ---------------- transmit ----------------
  logic [7:0] tx_head;
  logic       tx_full, tx_empty, tx_pop;
  tx_state_e  tx_state_q;
  logic [3:0] tx_tcnt_q;
  logic [2:0] tx_bit_q;
  logic       tx_stop_q, tx_par_q, txd_q;
  logic [7:0] tx_shift_q;

  assign tx_pop = (tx_state_q == TX_IDLE) && !tx_empty;

  sync_fifo #(.width(8), .depth(fifo_depth)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_wr), .pop(tx_pop),
    .din(tx_data), .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else if (tx_state_q == TX_IDLE) begin
      txd_q <= 1'b1;
      if (!tx_empty) begin
        tx_state_q <= TX_START;
        txd_q      <= 1'b0;
        tx_tcnt_q  <= '0;
        tx_shift_q <= tx_head & mask_c;
        tx_par_q   <= parity_bit(tx_head & mask_c, par_mode_c);
      end
    end else if (tick16) begin
      tx_tcnt_q <= tx_tcnt_q + 4'd1;
      if (tx_tcnt_q == 4'd15) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_q <= TX_DATA;
            tx_bit_q   <= '0;
            txd_q      <= tx_shift_q[0];
          end
          TX_DATA: begin
            if (tx_bit_q != last_c) begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              txd_q      <= tx_shift_q[1];
            end else if (has_par_c) begin
              tx_state_q <= TX_PARITY;
              txd_q      <= tx_par_q;
            end else begin
              tx_state_q <= TX_STOP;
              tx_stop_q  <= 1'b0;
              txd_q      <= 1'b1;
            end
          end
          TX_PARITY: begin
            tx_state_q <= TX_STOP;
            tx_stop_q  <= 1'b0;
            txd_q      <= 1'b1;
          end
          TX_STOP: begin
            if (tx_stop_q == stop2_c) tx_state_q <= TX_IDLE;
            else                      tx_stop_q  <= 1'b1;
          end
          default: tx_state_q <= TX_IDLE;
        endcase
      end
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = tx_full;
  assign tx_idle  = tx_empty && (tx_state_q == TX_IDLE);

  // ---------------- receive ----------------
  logic       rx_meta_q, rx_sync_q;
  rx_state_e  rx_state_q;
  logic [3:0] rx_tcnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic       rx_par_q, rx_push_q, rx_par_err;
  logic [8:0] rx_entry_q, rx_head;
  logic       rx_full, rx_empty, rx_overrun_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxd;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_par_err = has_par_c && (rx_par_q != parity_bit(rx_shift_q, par_mode_c));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_push_q  <= 1'b0;
      rx_entry_q <= '0;
    end else begin
      rx_push_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_tcnt_q  <= '0;
            rx_shift_q <= '0;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: begin
          if (tick16) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            // Start bit is re-checked at its centre; later bits are a full bit apart.
            if (rx_state_q == RX_START && rx_tcnt_q == 4'd7) begin
              rx_tcnt_q <= '0;
              if (rx_sync_q) begin
                rx_state_q <= RX_IDLE;
              end else begin
                rx_state_q <= RX_DATA;
                rx_bit_q   <= '0;
              end
            end else if (rx_state_q != RX_START && rx_tcnt_q == 4'd15) begin
              case (rx_state_q)
                RX_DATA: begin
                  rx_shift_q[rx_bit_q] <= rx_sync_q;
                  if (rx_bit_q != last_c) rx_bit_q   <= rx_bit_q + 3'd1;
                  else if (has_par_c)     rx_state_q <= RX_PARITY;
                  else                    rx_state_q <= RX_STOP;
                end
                RX_PARITY: begin
                  rx_par_q   <= rx_sync_q;
                  rx_state_q <= RX_STOP;
                end
                RX_STOP: begin
                  rx_push_q  <= 1'b1;
                  rx_entry_q <= {rx_par_err || !rx_sync_q, rx_shift_q};
                  if (rx_sync_q) rx_state_q <= RX_IDLE;
                  else           rx_state_q <= RX_WAIT_HIGH;
                end
                default: rx_state_q <= RX_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  sync_fifo #(.width(9), .depth(fifo_depth)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push_q), .pop(rx_ack),
    .din(rx_entry_q), .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_overrun_q <= 1'b0;
    else          rx_overrun_q <= rx_push_q && rx_full && !rx_ack;
  end

  assign rx_data    = rx_head[7:0];
  assign rx_error   = rx_head[8];
  assign rx_avail   = !rx_empty;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered: an 8N1 instance (loopback or bench-driven line)
// and a 7E2 loopback instance with parity-bit corruption.
module tb_uart_buffered;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 8N1, depth 4
  logic       a_loop = 1'b1, a_drv = 1'b1, a_rxd, a_txd;
  logic [7:0] a_tx_data = 8'h00;
  logic       a_tx_wr = 1'b0, a_tx_busy, a_tx_idle;
  logic [7:0] a_rx_data;
  logic       a_rx_error, a_rx_avail, a_rx_ack = 1'b0, a_rx_overrun;
  assign a_rxd = a_loop ? a_txd : a_drv;

  uart_buffered #(.freq_hz(50000000), .baud(3125000), .data_bits(8), .parity(0),
                  .stop_bits(1), .fifo_depth(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .uart_rxd(a_rxd), .uart_txd(a_txd),
    .tx_data(a_tx_data), .tx_wr(a_tx_wr), .tx_busy(a_tx_busy), .tx_idle(a_tx_idle),
    .rx_data(a_rx_data), .rx_error(a_rx_error), .rx_avail(a_rx_avail),
    .rx_ack(a_rx_ack), .rx_overrun(a_rx_overrun)
  );

  // 7E2, depth 4, loopback through a corruption XOR
  logic       b_corrupt = 1'b0, b_rxd, b_txd;
  logic [7:0] b_tx_data = 8'h00;
  logic       b_tx_wr = 1'b0, b_tx_busy, b_tx_idle;
  logic [7:0] b_rx_data;
  logic       b_rx_error, b_rx_avail, b_rx_ack = 1'b0, b_rx_overrun;
  assign b_rxd = b_txd ^ b_corrupt;

  uart_buffered #(.freq_hz(50000000), .baud(3125000), .data_bits(7), .parity(2),
                  .stop_bits(2), .fifo_depth(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .uart_rxd(b_rxd), .uart_txd(b_txd),
    .tx_data(b_tx_data), .tx_wr(b_tx_wr), .tx_busy(b_tx_busy), .tx_idle(b_tx_idle),
    .rx_data(b_rx_data), .rx_error(b_rx_error), .rx_avail(b_rx_avail),
    .rx_ack(b_rx_ack), .rx_overrun(b_rx_overrun)
  );

  int total = 0;
  int bad = 0;
  int a_ovr_cnt = 0;

  always @(negedge clk) if (a_rx_overrun === 1'b1) a_ovr_cnt <= a_ovr_cnt + 1;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    @(negedge clk);
    a_tx_data = d;
    a_tx_wr   = 1'b1;
    @(negedge clk);
    a_tx_wr   = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    @(negedge clk);
    b_tx_data = d;
    b_tx_wr   = 1'b1;
    @(negedge clk);
    b_tx_wr   = 1'b0;
  endtask

  task automatic ack_a;
    a_rx_ack = 1'b1;
    @(negedge clk);
    a_rx_ack = 1'b0;
  endtask

  task automatic expect_a(input string name, input logic [7:0] d, input logic e);
    int n;
    n = 0;
    while (a_rx_avail !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_avail"}, 32'(a_rx_avail), 32'd1);
    check({name, "_data"}, 32'(a_rx_data), 32'(d));
    check({name, "_err"}, 32'(a_rx_error), 32'(e));
    ack_a();
  endtask

  task automatic wait_fall(input logic is_b);
    int n;
    n = 0;
    while ((is_b ? b_txd : a_txd) !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(is_b ? "b_txd_fall" : "a_txd_fall", 32'(is_b ? b_txd : a_txd), 32'd0);
  endtask

  // Drive one 8N1 frame on dut_a's line, then two idle bit times.
  task automatic send_rx(input logic [7:0] d, input logic stop_lvl);
    logic [9:0] f;
    f = {stop_lvl, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      a_drv = f[i];
      repeat (16) @(negedge clk);
    end
    a_drv = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int ovr_base;
    logic [10:0] cap;

    vecs[0] = '{tx: 8'hA3, exp_data: 8'hA3, exp_err: 1'b0};
    vecs[1] = '{tx: 8'h00, exp_data: 8'h00, exp_err: 1'b0};
    vecs[2] = '{tx: 8'hFF, exp_data: 8'hFF, exp_err: 1'b0};
    vecs[3] = '{tx: 8'h81, exp_data: 8'h81, exp_err: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(a_txd), 32'd1);
    check("rst_busy", 32'(a_tx_busy), 32'd0);
    check("rst_idle", 32'(a_tx_idle), 32'd1);
    check("rst_avail", 32'(a_rx_avail), 32'd0);
    check("rst_rx_data", 32'(a_rx_data), 32'd0);
    check("rst_rx_err", 32'(a_rx_error), 32'd0);
    check("rst_overrun", 32'(a_rx_overrun), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1: start-bit width and frame length for 0x55
    push_a(8'h55);
    wait_fall(1'b0);
    n = 0;
    while (a_txd === 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_bit_cycles", 32'(n), 32'd16);
    while (a_tx_idle !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_cycles", 32'(n), 32'd160);
    expect_a("lb_55", 8'h55, 1'b0);

    for (int i = 0; i < 4; i++) begin
      push_a(vecs[i].tx);
      expect_a($sformatf("lb_vec%0d", i), vecs[i].exp_data, vecs[i].exp_err);
    end

    // TX FIFO full: engine busy with 0x11, then six back-to-back writes
    push_a(8'h11);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      a_tx_data = 8'h21 + 8'(i);
      a_tx_wr   = 1'b1;
      @(negedge clk);
      if (i == 2) check("busy_after_3", 32'(a_tx_busy), 32'd0);
      if (i == 3) check("busy_after_4", 32'(a_tx_busy), 32'd1);
    end
    a_tx_wr = 1'b0;
    expect_a("full_0", 8'h11, 1'b0);
    expect_a("full_1", 8'h21, 1'b0);
    expect_a("full_2", 8'h22, 1'b0);
    expect_a("full_3", 8'h23, 1'b0);
    expect_a("full_4", 8'h24, 1'b0);
    repeat (300) @(negedge clk);
    check("full_no_extra", 32'(a_rx_avail), 32'd0);
    check("full_tx_idle", 32'(a_tx_idle), 32'd1);

    // RX overrun: five frames, no ack
    a_loop = 1'b0;
    repeat (4) @(negedge clk);
    ovr_base = a_ovr_cnt;
    for (int i = 0; i < 5; i++) send_rx(8'h10 + 8'(i), 1'b1);
    check("overrun_pulses", 32'(a_ovr_cnt - ovr_base), 32'd1);
    for (int i = 0; i < 4; i++) expect_a($sformatf("ovr_keep%0d", i), 8'h10 + 8'(i), 1'b0);
    check("ovr_drained", 32'(a_rx_avail), 32'd0);

    // Fifth store coincides with an ack: no drop
    ovr_base = a_ovr_cnt;
    for (int i = 0; i < 4; i++) send_rx(8'h20 + 8'(i), 1'b1);
    @(negedge clk);
    fork
      send_rx(8'h24, 1'b1);
      begin
        repeat (155) @(negedge clk);
        a_rx_ack = 1'b1;
        @(negedge clk);
        a_rx_ack = 1'b0;
      end
    join
    check("ack_same_cycle_no_ovr", 32'(a_ovr_cnt - ovr_base), 32'd0);
    for (int i = 0; i < 4; i++) expect_a($sformatf("ack_keep%0d", i), 8'h21 + 8'(i), 1'b0);

    // False start: 4-cycle glitch
    a_drv = 1'b0;
    repeat (4) @(negedge clk);
    a_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_nothing", 32'(a_rx_avail), 32'd0);

    // Break: line low for 20 bit times
    a_drv = 1'b0;
    expect_a("break", 8'h00, 1'b1);
    repeat (150) @(negedge clk);
    check("break_single_entry", 32'(a_rx_avail), 32'd0);
    a_drv = 1'b1;
    repeat (32) @(negedge clk);
    send_rx(8'h5A, 1'b1);
    expect_a("after_break", 8'h5A, 1'b0);
    a_loop = 1'b1;

    // 7E2: capture line bits of 0x41 and corrupt the parity bit on the loop
    push_b(8'h41);
    wait_fall(1'b1);
    cap = '0;
    for (int c = 0; c < 176; c++) begin
      if (c == 130) b_corrupt = 1'b1;
      if (c == 146) b_corrupt = 1'b0;
      if (c % 16 == 8) cap[c / 16] = b_txd;
      if (c == 175) check("b_idle_before_end", 32'(b_tx_idle), 32'd0);
      @(negedge clk);
    end
    check("b_frame_bits", 32'(cap), 32'h682);
    check("b_idle_after_stop", 32'(b_tx_idle), 32'd1);
    n = 0;
    while (b_rx_avail !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b_par_data", 32'(b_rx_data), 32'h41);
    check("b_par_err", 32'(b_rx_error), 32'd1);
    b_rx_ack = 1'b1;
    @(negedge clk);
    b_rx_ack = 1'b0;
    push_b(8'h41);
    n = 0;
    while (b_rx_avail !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("b_clean_data", 32'(b_rx_data), 32'h41);
    check("b_clean_err", 32'(b_rx_error), 32'd0);

    // Reset during DATA bits
    push_a(8'hF0);
    wait_fall(1'b0);
    repeat (40) @(negedge clk);
    check("pre_reset_txd_busy", 32'(a_tx_idle), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset_txd", 32'(a_txd), 32'd1);
    check("mid_reset_idle", 32'(a_tx_idle), 32'd1);
    check("mid_reset_avail", 32'(a_rx_avail), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    push_a(8'h3C);
    expect_a("post_reset", 8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("post_reset_idle", 32'(a_tx_idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_buffered.md
# uart_buffered

Parametrised successor to the plain UART used by the system and its testbench comm partner. It adds configurable frame format (5–8 data bits, none/odd/even parity, 1 or 2 stop bits), 16x-oversampled reception, and TX/RX FIFOs. Each received byte carries its own error flag. It sits between a bus/testbench master and the `uart_txd`/`uart_rxd` pins and keeps the existing `rx_*`/`tx_*` handshake names.

## Interface
Parameters:
- `freq_hz`, 50000000: clock frequency in Hz.
- `baud`, 115200: bit rate. Divider `div = (freq_hz + 8*baud) / (16*baud)`, must be ≥1.
- `data_bits`, 8: 5..8. Unused high bits of `rx_data` read 0; unused `tx_data` bits are ignored.
- `parity`, 0: 0 = none, 1 = odd, 2 = even.
- `stop_bits`, 1: 1 or 2 on TX. RX checks only the first stop bit.
- `fifo_depth`, 16: power of two, ≥2, applies to both FIFOs.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `uart_rxd` in 1: serial input, asynchronous, idle high.
- `uart_txd` out 1: serial output, registered, idle high.
- `tx_data` in 8: byte to send.
- `tx_wr` in 1: push `tx_data` into the TX FIFO.
- `tx_busy` out 1: TX FIFO full.
- `tx_idle` out 1: TX FIFO empty and no frame in flight.
- `rx_data` out 8: head of the RX FIFO (show-ahead).
- `rx_error` out 1: parity or framing error flag of the head entry.
- `rx_avail` out 1: RX FIFO not empty.
- `rx_ack` in 1: pop the head entry.
- `rx_overrun` out 1: one-cycle pulse when a received byte is dropped.

## Operation
- Tick generator: counter `0..div-1`, producing a 1-cycle `tick16` enable. It free-runs.
- TX FSM: IDLE → START → DATA → PARITY (skipped if `parity`=0) → STOP → IDLE.
  - Each state lasts 16 ticks. STOP lasts 16 × `stop_bits` ticks.
  - DATA is LSB first, `data_bits` bits. Parity is computed over the data bits only.
  - In IDLE with the FIFO non-empty, the FSM pops the FIFO and enters START.
- RX path: 2-FF synchroniser on `uart_rxd`. RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a low level on the synchronised input starts the tick count.
  - START: re-sample at tick 8. If high, it is a false start; return to IDLE and enqueue nothing.
  - DATA/PARITY/STOP: sample every 16 ticks at bit centre.
  - STOP sample: enqueue `{error, data}`, where error = parity mismatch OR stop bit low.
  - If the stop bit is low (framing error or break), go to WAIT_HIGH and stay there until the input is high. Otherwise go to IDLE.
- FIFO push rules:
  - TX push accepted when `tx_wr` && (!full || engine pops the same cycle).
  - RX push accepted when !full || `rx_ack` pops the same cycle; otherwise the byte is dropped and `rx_overrun` pulses.
- `rx_ack` while `rx_avail`=0 is ignored. Pop and push in the same cycle on a non-full FIFO leave the count unchanged.

## Timing
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_idle`=1, `rx_avail`=0, `rx_data`=0, `rx_error`=0, `rx_overrun`=0. All FSMs go to IDLE, FIFOs are emptied, counters are zeroed.
- Reset asserted mid-frame: `uart_txd` goes high immediately (asynchronously). Any partial RX byte is discarded.
- TX latency: `tx_wr` sampled at edge N with an idle engine → `uart_txd` falls no later than edge N+2 + `div`.
- Bit time: `16*div` cycles. A full frame is `16*div*(1 + data_bits + (parity≠0) + stop_bits)` cycles.
- `tx_idle` rises on the cycle after the last stop bit completes.
- RX latency: entry written 1 cycle after the stop-bit centre sample; `rx_avail` and `rx_data` are valid on the next cycle.
- `rx_data`/`rx_error` change only on push-to-empty or pop.
- `tx_busy` and `rx_avail` are registered from the FIFO counts.

## Structure
- Package `uart_pkg`: parity enum (NONE/ODD/EVEN), TX and RX state enums, and a divider function `uart_div(freq_hz, baud)`.
- Sub-module `sync_fifo`: parameters `width`, `depth`; ports `push`, `pop`, `din`, `dout` (show-ahead), `full`, `empty`. Instantiated twice: 8-bit TX, 9-bit RX (`{error, data}`).

## Test plan
Common setup: `freq_hz`=50e6, `baud`=3125000 (`div`=1, 16-cycle bit), `fifo_depth`=4, `uart_txd` looped to `uart_rxd` unless stated.

- 8N1 loopback: push 0x55, 0xA3 → RX entries 0x55 then 0xA3 with `rx_error`=0. TX start-bit width is exactly 16 cycles; the frame is 160 cycles.
- 7E2: push 0x41 → `uart_txd` carries start, 1000001 (LSB first), parity 0, two stop bits. Bench corrupts the parity bit → entry 0x41 with `rx_error`=1.
- TX full: 6 back-to-back `tx_wr` while the engine is busy → `tx_busy`=1 after 4 are stored and later writes are dropped. Accepted bytes appear in order; `tx_idle`=1 after the last stop bit.
- RX overrun: bench sends 5 frames with no `rx_ack` → `rx_overrun` pulses once and the FIFO holds the first 4. `rx_ack` on the same cycle as the 5th store → no overrun.
- False start and break:
  - 4-cycle low glitch → nothing enqueued.
  - `uart_rxd` held low for 20 bit times → one entry 0x00 with `rx_error`=1. No further entries until the line returns high, then 0x5A is received correctly.
- Reset mid-TX: drop `reset_n` during the DATA bits → `uart_txd`=1 in the same cycle, `tx_idle`=1, `rx_avail`=0. After release, a new byte transmits normally.
